imm_decode_stage: RTL and testbench
===================================

# imm_decode_stage

Registered, flow-controlled immediate-decode stage for the fetch→execute path. It takes one 32-bit instruction per handshake and classifies its immediate format from the opcode. It then builds the sign- or zero-extended immediate at parametrised XLEN width and presents the result through a 2-entry output buffer with valid/ready handshakes on both sides. It sits between the instruction fetch buffer and the register-read/execute stage, replacing the separate combinational opcode-classify and immediate-build logic.

## Interface
- XLEN, 32: immediate output width; legal values 32 and 64
- TAG_W, 32: width of sideband tag (PC) carried alongside each instruction
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous discard of all buffered entries
- in_valid  input  1  upstream offers in_ins/in_tag
- in_ready  output  1  stage can accept this cycle
- in_ins  input  32  raw instruction word
- in_tag  input  TAG_W  sideband tag, passed through unmodified
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream accepts head entry
- out_imm  output  XLEN  decoded immediate
- out_imm_type  output  3  format code: 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z (CSR zimm)
- out_illegal  output  1  op_code[1:0] != 2'b11
- out_tag  output  TAG_W  tag of head entry

## Operation
- Classify on in_ins[6:2]:
  - 00000 LOAD, 00100 OP_IMM, 11001 JALR → I
  - 01000 STORE → S
  - 11000 BRANCH → B
  - 00101 AUIPC, 01101 LUI → U
  - 11011 JAL → J
  - 11100 SYSTEM → Z when ZICSR is enabled and funct3[2]=1; otherwise none
  - all other opcodes → none
- When in_ins[1:0] != 2'b11: type none, out_illegal=1.
- I/S/B/U/J immediates use the standard RISC-V bit scatter. B and J have bit 0 = 0. U has bits 11:0 = 0.
- All of I/S/B/U/J are sign-extended from ins[31] to XLEN; for XLEN=64, U is also sign-extended from bit 31.
- Z immediate: ins[19:15] zero-extended to XLEN.
- Type none: out_imm = 0.
- Decode is performed on the input side. Buffer entries store {imm, type, illegal, tag}.
- 2-entry FIFO, count 0..2:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
  - in_ready = (count != 2); a registered state function, never combinationally dependent on out_ready
  - out_valid = (count != 0)
  - Output fields show the head entry and are stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop at count 1: count stays 1, head advances to the new entry. Push and pop at count 2 cannot occur because in_ready=0.
- Flush: count becomes 0 at the next edge. A push in the same cycle is discarded, and a pop in the same cycle is still treated as completed.
- Reset: count=0, in_ready=1, out_valid=0, out_imm=0, out_imm_type=0, out_illegal=0, out_tag=0. Asserting rst mid-transfer drops all entries immediately.

## Timing
- Latency: in_valid/in_ready accepted at edge N → out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 instruction/cycle sustained while out_ready=1.
- Backpressure:
  - out_ready low for 2 cycles with continuous input fills the buffer; in_ready drops the cycle after the second push.
  - The first pop re-raises in_ready the following cycle, with no lost or duplicated entries.
- No combinational path from any input to any output. All outputs come from registers or from count.

## Configuration
- IMM_ZICSR_EN defined: SYSTEM opcode with funct3[2]=1 yields type 6 (Z) and the zero-extended 5-bit zimm.
- IMM_ZICSR_EN undefined: SYSTEM decodes as type none with imm 0, and type code 6 is never produced.

## Test plan
- XLEN=32, push 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → next cycle out_valid=1, out_imm=0xFFFFFFFF, out_imm_type=1, out_illegal=0.
- XLEN=32, push 0xFE112E23 (sw x1,-4(x2)), then 0x123452B7 (lui x5,0x12345) → out_imm 0xFFFFFFFC type 2, then 0x12345000 type 4, in consecutive cycles.
- XLEN=64, push 0x800000B7 (lui x1,0x80000) → out_imm=0xFFFFFFFF80000000, type 4.
- Push 0x3002D073 (csrrwi x0,0x300,5):
  - with IMM_ZICSR_EN → out_imm=5, type 6
  - without IMM_ZICSR_EN → out_imm=0, type 0
- Backpressure: hold out_ready=0 and push 3 instructions with tags 0x100/0x104/0x108 → in_ready=0 after 2 accepted. Release out_ready → tags 0x100, then 0x104, then 0x108 appear in order with no duplicates.
- With count=2:
  - assert flush for one cycle → out_valid=0, in_ready=1 next cycle
  - separately, assert rst asynchronously mid-cycle → out_valid=0 and all outputs 0 immediately
  - push 0x00000013 with in_ins[1:0] forced to 2'b00 → out_illegal=1, type 0, imm 0

Source files
------------

// File: rtl/imm_decode_stage_if.sv
// Handshake bundle for imm_decode_stage: upstream instruction offer, downstream decoded entry, flush.
// master = side driving instructions and consuming results; slave = the decode stage itself.
interface imm_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_ins;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_imm_type;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, in_ins, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_imm_type, out_illegal, out_tag
    );

    modport slave (
        input  flush, in_valid, in_ins, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_imm_type, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: classify opcode, build XLEN immediate, buffer in a 2-entry FIFO.
// Optional CSR zimm decode enabled by defining IMM_ZICSR_EN.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic              clk,
    input logic              rst,
    imm_decode_stage_if.slave bus
);
    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_I    = 3'd1;
    localparam logic [2:0] TYPE_S    = 3'd2;
    localparam logic [2:0] TYPE_B    = 3'd3;
    localparam logic [2:0] TYPE_U    = 3'd4;
    localparam logic [2:0] TYPE_J    = 3'd5;
    localparam logic [2:0] TYPE_Z    = 3'd6;

`ifdef IMM_ZICSR_EN
    localparam bit ZICSR_EN = 1'b1;
`else
    localparam bit ZICSR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       imm_type;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] ins;
    entry_t      entry_d;
    entry_t      mem_q [2];
    entry_t      head;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        push, pop, wr_en;

    assign ins = bus.in_ins;

    // Decode happens before the buffer so the output side is a pure register read.
    always_comb begin
        entry_d     = '0;
        entry_d.tag = bus.in_tag;
        if (ins[1:0] != 2'b11) begin
            entry_d.illegal = 1'b1;
        end else begin
            unique case (ins[6:2])
                5'b00000, 5'b00100, 5'b11001: begin
                    entry_d.imm_type = TYPE_I;
                    entry_d.imm      = {{(XLEN-11){ins[31]}}, ins[30:20]};
                end
                5'b01000: begin
                    entry_d.imm_type = TYPE_S;
                    entry_d.imm      = {{(XLEN-11){ins[31]}}, ins[30:25], ins[11:7]};
                end
                5'b11000: begin
                    entry_d.imm_type = TYPE_B;
                    entry_d.imm      = {{(XLEN-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                end
                5'b00101, 5'b01101: begin
                    entry_d.imm_type = TYPE_U;
                    entry_d.imm      = {{(XLEN-31){ins[31]}}, ins[30:12], 12'b0};
                end
                5'b11011: begin
                    entry_d.imm_type = TYPE_J;
                    entry_d.imm      = {{(XLEN-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
                end
                5'b11100: begin
                    if (ZICSR_EN && ins[14]) begin
                        entry_d.imm_type = TYPE_Z;
                        entry_d.imm      = {{(XLEN-5){1'b0}}, ins[19:15]};
                    end
                end
                default: entry_d.imm_type = TYPE_NONE;
            endcase
        end
    end

    // in_ready depends only on registered count, so out_ready never reaches it combinationally.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign push  = bus.in_valid & bus.in_ready;
    assign pop   = bus.out_valid & bus.out_ready;
    assign wr_en = push & ~bus.flush;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (bus.flush) begin
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + 2'(push) - 2'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            // NOTE: the buffer is reset because its head is driven straight onto the outputs, which must read 0 in reset.
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (wr_en) mem_q[wr_ptr_q] <= entry_d;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign bus.out_imm      = head.imm;
    assign bus.out_imm_type = head.imm_type;
    assign bus.out_illegal  = head.illegal;
    assign bus.out_tag      = head.tag;
endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 stages driven in lockstep, checked against a queue-based model.
// Define IMM_ZICSR_EN consistently for bench and RTL to exercise the CSR zimm path.
module tb_imm_decode_stage;
    localparam int TAG_W = 32;

    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_OPIMM  = 5'b00100;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_JAL    = 5'b11011;
    localparam logic [4:0] OP_SYSTEM = 5'b11100;
    localparam logic [4:0] OP_OP     = 5'b01100;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_decode_stage_if #(.XLEN(32), .TAG_W(TAG_W)) if32 ();
    imm_decode_stage_if #(.XLEN(64), .TAG_W(TAG_W)) if64 ();

    imm_decode_stage #(.XLEN(32), .TAG_W(TAG_W)) dut32 (.clk(clk), .rst(rst), .bus(if32.slave));
    imm_decode_stage #(.XLEN(64), .TAG_W(TAG_W)) dut64 (.clk(clk), .rst(rst), .bus(if64.slave));

    int   checks = 0;
    int   errors = 0;
    exp_t mq[$];

    // Immediate computed arithmetically from the instruction's signed value and bit fields.
    function automatic exp_t ref_entry(input logic [31:0] ins, input logic [31:0] tag);
        exp_t   e;
        longint s, r;
        int     f7_5, f8_4, b7, f25_6, f12_8, b20, f21_10, f15_5;
        s = longint'(ins);
        if (ins[31]) s = s - 64'sh1_0000_0000;
        f7_5   = int'((ins >> 7) & 32'h1F);
        f8_4   = int'((ins >> 8) & 32'hF);
        b7     = int'((ins >> 7) & 32'h1);
        f25_6  = int'((ins >> 25) & 32'h3F);
        f12_8  = int'((ins >> 12) & 32'hFF);
        b20    = int'((ins >> 20) & 32'h1);
        f21_10 = int'((ins >> 21) & 32'h3FF);
        f15_5  = int'((ins >> 15) & 32'h1F);
        r      = 0;
        e.typ  = 3'd0;
        e.tag  = tag;
        e.ill  = (ins[1:0] != 2'b11);
        if (!e.ill) begin
            case (ins[6:2])
                OP_LOAD, OP_OPIMM, OP_JALR: begin e.typ = 3'd1; r = s >>> 20; end
                OP_STORE:  begin e.typ = 3'd2; r = (s >>> 25) * 32 + f7_5; end
                OP_BRANCH: begin e.typ = 3'd3; r = (s >>> 31) * 4096 + b7 * 2048 + f25_6 * 32 + f8_4 * 2; end
                OP_AUIPC, OP_LUI: begin e.typ = 3'd4; r = (s >>> 12) * 4096; end
                OP_JAL:    begin e.typ = 3'd5; r = (s >>> 31) * 1048576 + f12_8 * 4096 + b20 * 2048 + f21_10 * 2; end
`ifdef IMM_ZICSR_EN
                OP_SYSTEM: if (ins[14]) begin e.typ = 3'd6; r = f15_5; end
`endif
                default: r = 0;
            endcase
        end
        e.imm = r;
        return e;
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] tag,
                         input bit ordy, input bit fl);
        if32.in_valid = v;   if64.in_valid = v;
        if32.in_ins = ins;   if64.in_ins = ins;
        if32.in_tag = tag;   if64.in_tag = tag;
        if32.out_ready = ordy; if64.out_ready = ordy;
        if32.flush = fl;     if64.flush = fl;
    endtask

    // Called at a falling edge; drives inputs, crosses one rising edge, updates the model, returns at the next falling edge.
    task automatic tick(input bit v, input logic [31:0] ins, input logic [31:0] tag,
                        input bit ordy, input bit fl);
        bit push, pop;
        drive(v, ins, tag, ordy, fl);
        push = v && (mq.size() < 2);
        pop  = (mq.size() > 0) && ordy;
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (pop)  mq.delete(0);
            if (push) mq.push_back(ref_entry(ins, tag));
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 32'h0, 32'h0, 0, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", if32.out_valid); end
        checks++; if (if32.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", if32.in_ready); end
        checks++; if (if64.out_imm !== 64'h0) begin errors++; $display("FAIL reset_imm64: got %h want 0", if64.out_imm); end
        checks++; if (if32.out_imm_type !== 3'd0 || if32.out_illegal !== 1'b0 || if32.out_tag !== 32'h0)
            begin errors++; $display("FAIL reset_fields: type %0d ill %b tag %h want 0", if32.out_imm_type, if32.out_illegal, if32.out_tag); end
        rst = 1'b0;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_i_type();
        tick(1, 32'hFFF00093, 32'h10, 1, 0);
        checks++; if (if32.out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", if32.out_valid); end
        checks++; if (if32.out_imm !== 32'hFFFFFFFF) begin errors++; $display("FAIL addi_imm32: got %h want ffffffff", if32.out_imm); end
        checks++; if (if32.out_imm_type !== 3'd1) begin errors++; $display("FAIL addi_type: got %0d want 1", if32.out_imm_type); end
        checks++; if (if32.out_illegal !== 1'b0) begin errors++; $display("FAIL addi_illegal: got %b want 0", if32.out_illegal); end
        tick(0, 32'h0, 32'h0, 1, 0);
        checks++; if (if32.out_valid !== 1'b0) begin errors++; $display("FAIL addi_drain: got %b want 0", if32.out_valid); end
    endtask

    task automatic test_back_to_back();
        tick(1, 32'hFE112E23, 32'h20, 1, 0);
        checks++; if (if32.out_imm !== 32'hFFFFFFFC || if32.out_imm_type !== 3'd2)
            begin errors++; $display("FAIL sw_imm: got %h type %0d want fffffffc type 2", if32.out_imm, if32.out_imm_type); end
        checks++; if (if64.out_imm !== 64'hFFFFFFFFFFFFFFFC) begin errors++; $display("FAIL sw_imm64: got %h want fffffffffffffffc", if64.out_imm); end
        tick(1, 32'h123452B7, 32'h24, 1, 0);
        checks++; if (if32.out_imm !== 32'h12345000 || if32.out_imm_type !== 3'd4 || if32.out_tag !== 32'h24)
            begin errors++; $display("FAIL lui_imm: got %h type %0d tag %h want 12345000 type 4 tag 24", if32.out_imm, if32.out_imm_type, if32.out_tag); end
        tick(1, 32'h800000B7, 32'h28, 1, 0);
        checks++; if (if64.out_imm !== 64'hFFFFFFFF80000000 || if64.out_imm_type !== 3'd4)
            begin errors++; $display("FAIL lui64_imm: got %h type %0d want ffffffff80000000 type 4", if64.out_imm, if64.out_imm_type); end
        checks++; if (if32.out_imm !== 32'h80000000) begin errors++; $display("FAIL lui32_imm: got %h want 80000000", if32.out_imm); end
        tick(0, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic test_zicsr();
        logic [31:0] want_imm;
        logic [2:0]  want_type;
`ifdef IMM_ZICSR_EN
        want_imm = 32'd5; want_type = 3'd6;
`else
        want_imm = 32'd0; want_type = 3'd0;
`endif
        tick(1, 32'h3002D073, 32'h30, 1, 0);
        checks++; if (if32.out_imm !== want_imm || if32.out_imm_type !== want_type)
            begin errors++; $display("FAIL csrrwi: got %h type %0d want %h type %0d", if32.out_imm, if32.out_imm_type, want_imm, want_type); end
        checks++; if (if64.out_imm !== {32'h0, want_imm}) begin errors++; $display("FAIL csrrwi64: got %h want %h", if64.out_imm, want_imm); end
        tick(0, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] want_tag [6] = '{32'h100, 32'h100, 32'h100, 32'h104, 32'h108, 32'h0};
        bit          want_rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        bit          want_vld [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tick(1, 32'h00000013, 32'h100, 0, 0);
        for (int step = 0; step < 6; step++) begin
            if (step > 0) begin
                case (step)
                    1:       tick(1, 32'h00000013, 32'h104, 0, 0);
                    2:       tick(1, 32'h00000013, 32'h108, 0, 0);
                    3, 4:    tick(1, 32'h00000013, 32'h108, 1, 0);
                    default: tick(0, 32'h0, 32'h0, 1, 0);
                endcase
            end
            checks++; if (if32.in_ready !== want_rdy[step]) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", step, if32.in_ready, want_rdy[step]); end
            checks++; if (if32.out_valid !== want_vld[step]) begin errors++; $display("FAIL bp_valid[%0d]: got %b want %b", step, if32.out_valid, want_vld[step]); end
            if (want_vld[step]) begin
                checks++; if (if32.out_tag !== want_tag[step]) begin errors++; $display("FAIL bp_tag[%0d]: got %h want %h", step, if32.out_tag, want_tag[step]); end
            end
        end
    endtask

    task automatic test_flush();
        tick(1, 32'h00000013, 32'h200, 0, 0);
        tick(1, 32'h00000013, 32'h204, 0, 0);
        checks++; if (if32.in_ready !== 1'b0) begin errors++; $display("FAIL flush_full: in_ready got %b want 0", if32.in_ready); end
        tick(1, 32'h00000013, 32'h208, 0, 1);
        checks++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1)
            begin errors++; $display("FAIL flush_empty: valid %b in_ready %b want 0/1", if32.out_valid, if32.in_ready); end
        tick(0, 32'h0, 32'h0, 1, 0);
        checks++; if (if64.out_valid !== 1'b0) begin errors++; $display("FAIL flush_push_dropped: valid got %b want 0", if64.out_valid); end
    endtask

    task automatic test_async_reset();
        tick(1, 32'hFE112E23, 32'h300, 0, 0);
        tick(1, 32'hFE112E23, 32'h304, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++; if (if32.out_valid !== 1'b0 || if32.in_ready !== 1'b1)
            begin errors++; $display("FAIL arst_ctrl: valid %b in_ready %b want 0/1", if32.out_valid, if32.in_ready); end
        checks++; if (if32.out_imm !== 32'h0 || if32.out_imm_type !== 3'd0 || if32.out_illegal !== 1'b0 || if32.out_tag !== 32'h0)
            begin errors++; $display("FAIL arst_fields: imm %h type %0d ill %b tag %h want 0", if32.out_imm, if32.out_imm_type, if32.out_illegal, if32.out_tag); end
        checks++; if (if64.out_imm !== 64'h0) begin errors++; $display("FAIL arst_imm64: got %h want 0", if64.out_imm); end
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        @(negedge clk);
    endtask

    task automatic test_illegal();
        tick(1, 32'h00000010, 32'h400, 1, 0);
        checks++; if (if32.out_illegal !== 1'b1 || if32.out_imm_type !== 3'd0 || if32.out_imm !== 32'h0)
            begin errors++; $display("FAIL illegal: ill %b type %0d imm %h want 1/0/0", if32.out_illegal, if32.out_imm_type, if32.out_imm); end
        tick(0, 32'h0, 32'h0, 1, 0);
    endtask

    task automatic test_random();
        logic [4:0]  opc [10] = '{OP_LOAD, OP_OPIMM, OP_JALR, OP_STORE, OP_BRANCH,
                                  OP_AUIPC, OP_LUI, OP_JAL, OP_SYSTEM, OP_OP};
        logic [31:0] ins;
        exp_t        e;
        for (int n = 0; n < 400; n++) begin
            ins      = $urandom;
            ins[6:2] = opc[$urandom_range(0, 9)];
            ins[1:0] = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
            tick($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            checks++; if (if32.in_ready !== (mq.size() < 2) || if64.in_ready !== (mq.size() < 2))
                begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b/%b model count %0d", n, if32.in_ready, if64.in_ready, mq.size()); end
            checks++; if (if32.out_valid !== (mq.size() != 0) || if64.out_valid !== (mq.size() != 0))
                begin errors++; $display("FAIL rnd_valid[%0d]: got %b/%b model count %0d", n, if32.out_valid, if64.out_valid, mq.size()); end
            if (mq.size() != 0) begin
                e = mq[0];
                checks++; if (if32.out_imm !== e.imm[31:0] || if64.out_imm !== e.imm)
                    begin errors++; $display("FAIL rnd_imm[%0d]: got %h/%h want %h", n, if32.out_imm, if64.out_imm, e.imm); end
                checks++; if (if32.out_imm_type !== e.typ || if64.out_imm_type !== e.typ)
                    begin errors++; $display("FAIL rnd_type[%0d]: got %0d/%0d want %0d", n, if32.out_imm_type, if64.out_imm_type, e.typ); end
                checks++; if (if32.out_illegal !== e.ill || if32.out_tag !== e.tag || if64.out_tag !== e.tag)
                    begin errors++; $display("FAIL rnd_ill_tag[%0d]: ill %b tag %h want %b %h", n, if32.out_illegal, if32.out_tag, e.ill, e.tag); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_i_type();
        test_back_to_back();
        test_zicsr();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
